// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : MEM-stage load/store request/response bundle for dmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) ();
   logic              wr;
   logic              rd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [2:0]        funct3;
   logic              req_ready;
   logic              resp_valid;
   logic [DATA_W-1:0] rd_data;
   logic              resp_err;

   modport master (
      output wr, rd, addr, wr_data, funct3,
      input  req_ready, resp_valid, rd_data, resp_err
   );

   modport slave (
      input  wr, rd, addr, wr_data, funct3,
      output req_ready, resp_valid, rd_data, resp_err
   );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : 512-byte little-endian data RAM servicing byte/half/word
//            loads and stores with a fixed number of wait states.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 9,
   parameter int WAIT_CYC = 2
) (
   input  wire logic      clk,
   input  wire logic      reset,
   dmem_responder_if.slave bus
);

   localparam int         c_word_aw   = ADDR_W - 2;
   localparam int         c_words     = 1 << c_word_aw;
   localparam logic [3:0] c_wait_init = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

   localparam logic [1:0] c_st_idle = 2'd0;
   localparam logic [1:0] c_st_wait = 2'd1;
   localparam logic [1:0] c_st_resp = 2'd2;

   logic [1:0]        r_state;
   logic [3:0]        r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [2:0]        r_funct3;
   logic              r_rd;
   logic              r_wr;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_resp_err;

   logic              w_idle;
   logic              w_accept;
   logic              w_perform;
   logic              w_a_rd;
   logic              w_a_wr;
   logic [ADDR_W-1:0] w_a_addr;
   logic [DATA_W-1:0] w_a_wdata;
   logic [2:0]        w_a_funct3;
   logic [1:0]        w_size;
   logic              w_f3_ok;
   logic              w_misalign;
   logic              w_err;
   logic              w_mem_we;
   logic [3:0]        w_be;
   logic [DATA_W-1:0] w_wlanes;
   logic [c_word_aw-1:0] w_widx;
   logic [DATA_W-1:0] w_rword;
   logic [DATA_W-1:0] w_shift;
   logic [DATA_W-1:0] w_load;
   logic [DATA_W-1:0] w_resp_data;

   assign w_idle   = (r_state == c_st_idle);
   assign w_accept = w_idle && (bus.rd || bus.wr);

   // With zero wait states the access happens on the accept edge itself,
   // so the live bus is used instead of the latched copy.
   assign w_perform  = (w_accept && (WAIT_CYC == 0)) ||
                       ((r_state == c_st_wait) && (r_cnt == 4'd0));
   assign w_a_rd     = w_idle ? bus.rd      : r_rd;
   assign w_a_wr     = w_idle ? bus.wr      : r_wr;
   assign w_a_addr   = w_idle ? bus.addr    : r_addr;
   assign w_a_wdata  = w_idle ? bus.wr_data : r_wdata;
   assign w_a_funct3 = w_idle ? bus.funct3  : r_funct3;

   assign w_size     = w_a_funct3[1:0];
   assign w_f3_ok    = (w_size != 2'b11) &&
                       !(w_a_funct3[2] && (w_a_wr || w_a_funct3[1]));
   assign w_misalign = ((w_size == 2'd1) && w_a_addr[0]) ||
                       ((w_size == 2'd2) && (w_a_addr[1:0] != 2'b00));
   assign w_err      = (w_a_rd && w_a_wr) || !w_f3_ok || w_misalign;
   assign w_mem_we   = w_perform && w_a_wr && !w_err;
   assign w_widx     = w_a_addr[ADDR_W-1:2];

   always_comb begin
      w_be     = 4'b0000;
      w_wlanes = w_a_wdata;
      case (w_size)
         2'd0: begin
            w_be     = 4'b0001 << w_a_addr[1:0];
            w_wlanes = {4{w_a_wdata[7:0]}};
         end
         2'd1: begin
            w_be     = w_a_addr[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{w_a_wdata[15:0]}};
         end
         2'd2:    w_be = 4'b1111;
         default: w_be = 4'b0000;
      endcase
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      logic [7:0] r_mem [c_words];

      always_ff @(posedge clk) begin
         if (w_mem_we && w_be[i]) begin
            r_mem[w_widx] <= w_wlanes[8*i +: 8];
         end
      end

      assign w_rword[8*i +: 8] = r_mem[w_widx];
   end

   assign w_shift = w_rword >> {w_a_addr[1:0], 3'b000};

   always_comb begin
      w_load = '0;
      case (w_size)
         2'd0:    w_load = w_a_funct3[2] ? {24'd0, w_shift[7:0]}
                                         : {{24{w_shift[7]}}, w_shift[7:0]};
         2'd1:    w_load = w_a_funct3[2] ? {16'd0, w_shift[15:0]}
                                         : {{16{w_shift[15]}}, w_shift[15:0]};
         2'd2:    w_load = w_rword;
         default: w_load = '0;
      endcase
   end

   assign w_resp_data = (w_a_rd && !w_err) ? w_load : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= c_st_idle;
         r_cnt      <= 4'd0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_funct3   <= 3'd0;
         r_rd       <= 1'b0;
         r_wr       <= 1'b0;
         r_rd_data  <= '0;
         r_resp_err <= 1'b0;
      end else begin
         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_addr   <= bus.addr;
                  r_wdata  <= bus.wr_data;
                  r_funct3 <= bus.funct3;
                  r_rd     <= bus.rd;
                  r_wr     <= bus.wr;
                  if (WAIT_CYC == 0) begin
                     r_state    <= c_st_resp;
                     r_rd_data  <= w_resp_data;
                     r_resp_err <= w_err;
                  end else begin
                     r_state <= c_st_wait;
                     r_cnt   <= c_wait_init;
                  end
               end
            end
            c_st_wait: begin
               if (r_cnt == 4'd0) begin
                  r_state    <= c_st_resp;
                  r_rd_data  <= w_resp_data;
                  r_resp_err <= w_err;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            c_st_resp: begin
               r_state    <= c_st_idle;
               r_rd_data  <= '0;
               r_resp_err <= 1'b0;
            end
            default: r_state <= c_st_idle;
         endcase
      end
   end

   assign bus.req_ready  = w_idle;
   assign bus.resp_valid = (r_state == c_st_resp);
   assign bus.rd_data    = r_rd_data;
   assign bus.resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Randomized self-checking bench for dmem_responder against a
//            byte-array reference model (WAIT_CYC=2 and WAIT_CYC=0 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

   logic clk = 1'b0;
   logic reset_n2;
   logic reset_n0;
   always #5 clk = ~clk;

   dmem_responder_if #(.DATA_W(32), .ADDR_W(9)) if2 ();
   dmem_responder_if #(.DATA_W(32), .ADDR_W(9)) if0 ();

   dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(2)) dut2 (
      .clk   (clk),
      .reset (reset_n2),
      .bus   (if2.slave)
   );

   dmem_responder #(.DATA_W(32), .ADDR_W(9), .WAIT_CYC(0)) dut0 (
      .clk   (clk),
      .reset (reset_n0),
      .bus   (if0.slave)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] mem2 [512];

   // Reference: byte-array memory, legality from the RISC-V size/sign rules.
   function automatic void model(input bit rd, input bit wr, input logic [8:0] a,
                                 input logic [2:0] f3, input logic [31:0] wd,
                                 output bit err, output logic [31:0] data);
      int  nb;
      bit  legal;
      nb = 1 << f3[1:0];
      if (rd && !wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      else           legal = (f3 <= 3'd2);
      err  = (rd && wr) || !legal || ((int'(a) % nb) != 0);
      data = 32'd0;
      if (!err && wr) begin
         for (int i = 0; i < nb; i++) mem2[int'(a) + i] = wd[8*i +: 8];
      end
      if (!err && rd) begin
         for (int i = 0; i < nb; i++) data[8*i +: 8] = mem2[int'(a) + i];
         if (!f3[2] && nb < 4 && data[8*nb-1]) data = data | (32'hFFFF_FFFF << (8*nb));
      end
   endfunction

   task automatic issue2(input bit rd, input bit wr, input logic [8:0] a,
                         input logic [2:0] f3, input logic [31:0] wd,
                         output logic [31:0] d, output logic e, output int lat);
      @(negedge clk);
      if2.rd = rd; if2.wr = wr; if2.addr = a; if2.funct3 = f3; if2.wr_data = wd;
      @(posedge clk);
      #1;
      if2.rd = 1'b0; if2.wr = 1'b0;
      lat = -1; d = 'x; e = 1'bx;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (if2.resp_valid === 1'b1) begin
            lat = k; d = if2.rd_data; e = if2.resp_err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n2 = 1'b0; reset_n0 = 1'b0;
      if2.rd = 0; if2.wr = 0; if2.addr = '0; if2.funct3 = '0; if2.wr_data = '0;
      if0.rd = 0; if0.wr = 0; if0.addr = '0; if0.funct3 = '0; if0.wr_data = '0;
      repeat (3) @(negedge clk);
      total++; if (if2.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", if2.req_ready); end
      total++; if (if2.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", if2.resp_valid); end
      total++; if (if2.rd_data !== 32'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", if2.rd_data); end
      total++; if (if2.resp_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", if2.resp_err); end
      total++; if (if0.req_ready !== 1'b1 || if0.resp_valid !== 1'b0) begin
         bad++; $display("FAIL rst0 ready=%b valid=%b exp 1/0", if0.req_ready, if0.resp_valid);
      end
      reset_n2 = 1'b1; reset_n0 = 1'b1;
   endtask

   task automatic test_store_load();
      logic [31:0] d, ed; logic e; bit ee; int lat;
      model(0, 1, 9'h010, 3'd2, 32'hDEADBEEF, ee, ed);
      issue2(0, 1, 9'h010, 3'd2, 32'hDEADBEEF, d, e, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL sw_latency got=%0d exp=3", lat); end
      total++; if (e !== ee || d !== ed) begin bad++; $display("FAIL sw_resp got=%h/%b exp=%h/%b", d, e, ed, ee); end
      model(1, 0, 9'h010, 3'd2, 32'd0, ee, ed);
      issue2(1, 0, 9'h010, 3'd2, 32'd0, d, e, lat);
      total++; if (lat !== 3) begin bad++; $display("FAIL lw_latency got=%0d exp=3", lat); end
      total++; if (d !== ed || ed !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=%h", d, ed); end
      total++; if (e !== 1'b0) begin bad++; $display("FAIL lw_err got=%b exp=0", e); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] d, ed; logic e; bit ee; int lat;
      model(0, 1, 9'h020, 3'd2, 32'h0, ee, ed);
      issue2(0, 1, 9'h020, 3'd2, 32'h0, d, e, lat);
      model(0, 1, 9'h021, 3'd0, 32'h80, ee, ed);
      issue2(0, 1, 9'h021, 3'd0, 32'h80, d, e, lat);
      total++; if (e !== 1'b0) begin bad++; $display("FAIL sb_err got=%b exp=0", e); end
      model(1, 0, 9'h021, 3'd0, 32'h0, ee, ed);
      issue2(1, 0, 9'h021, 3'd0, 32'h0, d, e, lat);
      total++; if (d !== ed) begin bad++; $display("FAIL lb_sext got=%h exp=%h", d, ed); end
      model(1, 0, 9'h021, 3'd4, 32'h0, ee, ed);
      issue2(1, 0, 9'h021, 3'd4, 32'h0, d, e, lat);
      total++; if (d !== ed) begin bad++; $display("FAIL lbu_zext got=%h exp=%h", d, ed); end
      model(1, 0, 9'h020, 3'd2, 32'h0, ee, ed);
      issue2(1, 0, 9'h020, 3'd2, 32'h0, d, e, lat);
      total++; if (d !== ed) begin bad++; $display("FAIL lw_lane got=%h exp=%h", d, ed); end
   endtask

   task automatic test_errors();
      logic [31:0] d, ed; logic e; bit ee; int lat;
      model(0, 1, 9'h100, 3'd2, 32'h0BADF00D, ee, ed);
      issue2(0, 1, 9'h100, 3'd2, 32'h0BADF00D, d, e, lat);
      model(1, 0, 9'h003, 3'd1, 32'h0, ee, ed);
      issue2(1, 0, 9'h003, 3'd1, 32'h0, d, e, lat);
      total++; if (e !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL lh_misalign got=%h/%b exp=0/1", d, e); end
      model(0, 1, 9'h102, 3'd2, 32'hFFFFFFFF, ee, ed);
      issue2(0, 1, 9'h102, 3'd2, 32'hFFFFFFFF, d, e, lat);
      total++; if (e !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL sw_misalign got=%h/%b exp=0/1", d, e); end
      model(1, 0, 9'h100, 3'd2, 32'h0, ee, ed);
      issue2(1, 0, 9'h100, 3'd2, 32'h0, d, e, lat);
      total++; if (d !== ed || e !== 1'b0) begin bad++; $display("FAIL lw_after_err got=%h exp=%h", d, ed); end
   endtask

   task automatic test_conflict();
      logic [31:0] d, ed; logic e; bit ee; int lat;
      model(0, 1, 9'h040, 3'd2, 32'hA5A5_5A5A, ee, ed);
      issue2(0, 1, 9'h040, 3'd2, 32'hA5A5_5A5A, d, e, lat);
      model(1, 1, 9'h040, 3'd2, 32'h12345678, ee, ed);
      issue2(1, 1, 9'h040, 3'd2, 32'h12345678, d, e, lat);
      total++; if (e !== 1'b1 || d !== 32'd0) begin bad++; $display("FAIL rdwr_conflict got=%h/%b exp=0/1", d, e); end
      model(1, 0, 9'h040, 3'd2, 32'h0, ee, ed);
      issue2(1, 0, 9'h040, 3'd2, 32'h0, d, e, lat);
      total++; if (d !== ed) begin bad++; $display("FAIL lw_after_conflict got=%h exp=%h", d, ed); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d, ed; logic e; bit ee; int lat; bit seen;
      model(0, 1, 9'h050, 3'd2, 32'h1111_2222, ee, ed);
      issue2(0, 1, 9'h050, 3'd2, 32'h1111_2222, d, e, lat);
      @(negedge clk);
      if2.wr = 1; if2.rd = 0; if2.addr = 9'h050; if2.funct3 = 3'd2; if2.wr_data = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      if2.wr = 0;
      @(negedge clk);
      total++; if (if2.req_ready !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", if2.req_ready); end
      reset_n2 = 1'b0;
      #1;
      total++; if (if2.req_ready !== 1'b1 || if2.resp_valid !== 1'b0) begin
         bad++; $display("FAIL mid_rst_ctrl ready=%b valid=%b exp 1/0", if2.req_ready, if2.resp_valid);
      end
      total++; if (if2.rd_data !== 32'd0 || if2.resp_err !== 1'b0) begin
         bad++; $display("FAIL mid_rst_out got=%h/%b exp=0/0", if2.rd_data, if2.resp_err);
      end
      seen = 0;
      repeat (3) begin @(negedge clk); if (if2.resp_valid !== 1'b0) seen = 1; end
      total++; if (seen) begin bad++; $display("FAIL mid_rst_pulse got=1 exp=0"); end
      reset_n2 = 1'b1;
      model(1, 0, 9'h050, 3'd2, 32'h0, ee, ed);
      issue2(1, 0, 9'h050, 3'd2, 32'h0, d, e, lat);
      total++; if (d !== ed || e !== 1'b0) begin bad++; $display("FAIL mid_rst_nowrite got=%h exp=%h", d, ed); end
   endtask

   task automatic test_random();
      logic [31:0] d, ed, wd; logic e; bit ee, rd, wr; int lat, r;
      logic [8:0] a; logic [2:0] f3;
      for (int w = 0; w < 128; w++) begin
         wd = $urandom;
         model(0, 1, 9'(w * 4), 3'd2, wd, ee, ed);
         issue2(0, 1, 9'(w * 4), 3'd2, wd, d, e, lat);
         total++; if (e !== 1'b0) begin bad++; $display("FAIL init_err addr=%h got=%b exp=0", w * 4, e); end
      end
      for (int n = 0; n < 200; n++) begin
         r  = $urandom_range(0, 9);
         rd = (r < 5);
         wr = (r >= 4);
         if ($urandom_range(0, 9) < 8) begin
            r  = $urandom_range(0, 4);
            f3 = (r == 3) ? 3'd4 : (r == 4) ? 3'd5 : 3'(r);
         end else begin
            f3 = 3'($urandom);
         end
         a  = 9'($urandom);
         if ($urandom_range(0, 9) < 7) a = a & ~9'((1 << f3[1:0]) - 1);
         wd = $urandom;
         model(rd, wr, a, f3, wd, ee, ed);
         issue2(rd, wr, a, f3, wd, d, e, lat);
         total++; if (lat !== 3) begin bad++; $display("FAIL rnd_latency n=%0d got=%0d exp=3", n, lat); end
         total++; if (e !== ee) begin bad++; $display("FAIL rnd_err n=%0d rd=%b wr=%b a=%h f3=%0d got=%b exp=%b", n, rd, wr, a, f3, e, ee); end
         total++; if (d !== ed) begin bad++; $display("FAIL rnd_data n=%0d a=%h f3=%0d got=%h exp=%h", n, a, f3, d, ed); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] val; bit exp_v;
      val = $urandom;
      @(negedge clk);
      if0.wr = 1; if0.rd = 0; if0.addr = 9'h010; if0.funct3 = 3'd2; if0.wr_data = val;
      @(posedge clk);
      #1;
      if0.wr = 0;
      @(negedge clk);
      total++; if (if0.resp_valid !== 1'b1 || if0.resp_err !== 1'b0) begin
         bad++; $display("FAIL b2b_sw_resp valid=%b err=%b exp 1/0", if0.resp_valid, if0.resp_err);
      end
      @(negedge clk);
      if0.rd = 1; if0.funct3 = 3'd2; if0.addr = 9'h010;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         exp_v = (k % 2) == 1;
         total++; if (if0.resp_valid !== exp_v || if0.req_ready !== !exp_v) begin
            bad++; $display("FAIL b2b_pulse k=%0d valid=%b ready=%b exp_valid=%b", k, if0.resp_valid, if0.req_ready, exp_v);
         end
         total++; if (if0.rd_data !== (exp_v ? val : 32'd0)) begin
            bad++; $display("FAIL b2b_data k=%0d got=%h exp=%h", k, if0.rd_data, exp_v ? val : 32'd0);
         end
      end
      if0.rd = 0;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_byte_lanes();
      test_errors();
      test_conflict();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
